pds_gnt_ctrl: RTL and testbench

- Responder end of the pds req/fault/gnt interface; owns `gnt` and drives it from the sampled `req` and `fault` inputs.
- Grants a request after a programmable latency and revokes the grant on fault or timeout.
- After a fault clears, enforces a recovery window before the next grant.
- Sits in the DUT next to the register block, which supplies the cfg_* inputs and reads the status outputs.

---
 rtl/pds_gnt_ctrl_if.sv | 10 +
 rtl/pds_gnt_ctrl.sv | 133 +++++++++++++
 tb/tb_pds_gnt_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pds_gnt_ctrl_if.sv
// pds request/fault/grant handshake between an initiator (master) and the
// grant controller (slave).
interface pds_gnt_ctrl_if;
    logic req;
    logic fault;
    logic gnt;

    modport master (output req, output fault, input gnt);
    modport slave  (input req, input fault, output gnt);
endinterface

// File: rtl/pds_gnt_ctrl.sv
// Responder side of the pds handshake: grants req after a programmable delay,
// revokes on fault or timeout, and enforces a recovery window after faults.
module pds_gnt_ctrl #(
    parameter int unsigned DLY_W       = 4,
    parameter int unsigned REC_W       = 8,
    parameter int unsigned MAX_GNT_CYC = 256,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pds_gnt_ctrl_if.slave     pds,
    input  logic [DLY_W-1:0]  cfg_gnt_dly,
    input  logic [REC_W-1:0]  cfg_recover,
    input  logic              fault_cnt_clr,
    output logic              fault_sts,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic              timeout_evt
);

    localparam int unsigned GCNT_W = (MAX_GNT_CYC > 0) ? $clog2(MAX_GNT_CYC + 1) : 1;
    localparam int unsigned GCNT_LAST_I = (MAX_GNT_CYC > 0) ? (MAX_GNT_CYC - 1) : 0;
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_LAST_I[GCNT_W-1:0];

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        GRANT,
        RELEASE,
        FAULT,
        RECOVER
    } state_t;

    state_t            state, state_nxt;
    logic [DLY_W-1:0]  dly_cnt, dly_nxt;
    logic [REC_W-1:0]  rec_cnt, rec_nxt;
    logic [GCNT_W-1:0] gnt_cnt, gnt_cnt_nxt;
    logic              timeout_nxt;
    logic              fault_entry;

    always_comb begin
        state_nxt   = state;
        dly_nxt     = dly_cnt;
        rec_nxt     = rec_cnt;
        gnt_cnt_nxt = '0;
        timeout_nxt = 1'b0;

        if (pds.fault && state != FAULT) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (pds.req) begin
                        if (cfg_gnt_dly == '0) begin
                            state_nxt = GRANT;
                        end else begin
                            state_nxt = WAIT;
                            dly_nxt   = cfg_gnt_dly;
                        end
                    end
                end
                WAIT: begin
                    if (!pds.req) begin
                        state_nxt = IDLE;
                    end else if (dly_cnt <= DLY_W'(1)) begin
                        state_nxt = GRANT;
                    end else begin
                        dly_nxt = dly_cnt - DLY_W'(1);
                    end
                end
                GRANT: begin
                    gnt_cnt_nxt = (gnt_cnt == '1) ? gnt_cnt : gnt_cnt + GCNT_W'(1);
                    if (!pds.req) begin
                        state_nxt = IDLE;
                    end else if (MAX_GNT_CYC != 0 && gnt_cnt == GCNT_LAST) begin
                        state_nxt   = RELEASE;
                        timeout_nxt = 1'b1;
                    end
                end
                RELEASE: begin
                    if (!pds.req) state_nxt = IDLE;
                end
                FAULT: begin
                    if (!pds.fault) begin
                        if (cfg_recover == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = RECOVER;
                            rec_nxt   = cfg_recover;
                        end
                    end
                end
                RECOVER: begin
                    if (rec_cnt <= REC_W'(1)) state_nxt = IDLE;
                    else                      rec_nxt   = rec_cnt - REC_W'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end

        // gnt_cnt restarts from zero on every entry into GRANT.
        if (state_nxt != GRANT) gnt_cnt_nxt = '0;

        fault_entry = (state_nxt == FAULT) && (state != FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dly_cnt     <= '0;
            rec_cnt     <= '0;
            gnt_cnt     <= '0;
            pds.gnt     <= 1'b0;
            fault_sts   <= 1'b0;
            fault_cnt   <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nxt;
            dly_cnt     <= dly_nxt;
            rec_cnt     <= rec_nxt;
            gnt_cnt     <= gnt_cnt_nxt;
            pds.gnt     <= (state_nxt == GRANT);
            fault_sts   <= (state_nxt == FAULT) || (state_nxt == RECOVER);
            timeout_evt <= timeout_nxt;
            // Clear takes effect first so a coinciding fault entry yields 1.
            if (fault_cnt_clr) begin
                fault_cnt <= fault_entry ? CNT_W'(1) : '0;
            end else if (fault_entry && fault_cnt != '1) begin
                fault_cnt <= fault_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pds_gnt_ctrl.sv
// Directed bench for pds_gnt_ctrl with hand-computed expectations; timeout
// limit lowered to 8 cycles so the forced release is reachable.
module tb_pds_gnt_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg_gnt_dly;
    logic [7:0] cfg_recover;
    logic       fault_cnt_clr;
    logic       fault_sts;
    logic [7:0] fault_cnt;
    logic       timeout_evt;

    int checks   = 0;
    int failures = 0;

    pds_gnt_ctrl_if pds ();

    pds_gnt_ctrl #(
        .DLY_W(4),
        .REC_W(8),
        .MAX_GNT_CYC(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pds(pds),
        .cfg_gnt_dly(cfg_gnt_dly),
        .cfg_recover(cfg_recover),
        .fault_cnt_clr(fault_cnt_clr),
        .fault_sts(fault_sts),
        .fault_cnt(fault_cnt),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; pds.req = 1'b0; pds.fault = 1'b0;
        cfg_gnt_dly = 4'd0; cfg_recover = 8'd0; fault_cnt_clr = 1'b0;
        tick(2);
        chk("rst_gnt", 32'(pds.gnt), 0);
        chk("rst_sts", 32'(fault_sts), 0);
        chk("rst_cnt", 32'(fault_cnt), 0);
        chk("rst_tmo", 32'(timeout_evt), 0);
        rst_n = 1'b1;
        tick(1);

        // zero-delay grant, held 5 cycles then released
        pds.req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t1_gnt_hi", 32'(pds.gnt), 1);
        end
        pds.req = 1'b0;
        tick(1);
        chk("t1_gnt_lo", 32'(pds.gnt), 0);
        chk("t1_cnt", 32'(fault_cnt), 0);

        // delay 3: grant on 4th edge
        cfg_gnt_dly = 4'd3;
        pds.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t2_wait", 32'(pds.gnt), 0);
        end
        tick(1);
        chk("t2_gnt", 32'(pds.gnt), 1);
        pds.req = 1'b0;
        tick(1);
        chk("t2_rel", 32'(pds.gnt), 0);
        // abort in WAIT
        pds.req = 1'b1;
        tick(2);
        pds.req = 1'b0;
        tick(3);
        chk("t2_abort", 32'(pds.gnt), 0);
        cfg_gnt_dly = 4'd0;
        pds.req = 1'b1;
        tick(1);
        chk("t2_idle_again", 32'(pds.gnt), 1);
        pds.req = 1'b0;
        tick(1);

        // timeout after 8 grant cycles
        pds.req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("t3_gnt_hi", 32'(pds.gnt), 1);
            chk("t3_tmo_lo", 32'(timeout_evt), 0);
        end
        tick(1);
        chk("t3_gnt_rel", 32'(pds.gnt), 0);
        chk("t3_tmo_pulse", 32'(timeout_evt), 1);
        tick(1);
        chk("t3_tmo_once", 32'(timeout_evt), 0);
        tick(10);
        chk("t3_no_regrant", 32'(pds.gnt), 0);
        pds.req = 1'b0;
        tick(1);
        chk("t3_idle", 32'(pds.gnt), 0);
        pds.req = 1'b1;
        tick(1);
        chk("t3_regrant", 32'(pds.gnt), 1);

        // fault for 3 samples during GRANT, recover window 4
        cfg_recover = 8'd4;
        pds.fault = 1'b1;
        tick(1);
        chk("t4_gnt_drop", 32'(pds.gnt), 0);
        chk("t4_sts", 32'(fault_sts), 1);
        chk("t4_cnt", 32'(fault_cnt), 1);
        tick(2);
        pds.fault = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t4_rec_gnt", 32'(pds.gnt), 0);
            chk("t4_rec_sts", 32'(fault_sts), 1);
        end
        tick(1);
        chk("t4_idle_gnt", 32'(pds.gnt), 0);
        chk("t4_idle_sts", 32'(fault_sts), 0);
        tick(1);
        chk("t4_regrant", 32'(pds.gnt), 1);
        chk("t4_cnt_end", 32'(fault_cnt), 1);

        // one-cycle fault from GRANT, then re-pulse inside RECOVER
        pds.fault = 1'b1;
        tick(1);
        chk("t5_cnt2", 32'(fault_cnt), 2);
        pds.fault = 1'b0;
        tick(2);
        pds.fault = 1'b1;
        tick(1);
        chk("t5_cnt3", 32'(fault_cnt), 3);
        pds.fault = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t5_rec_full", 32'(fault_sts), 1);
        end
        tick(1);
        chk("t5_rec_done", 32'(fault_sts), 0);
        tick(1);
        chk("t5_regrant", 32'(pds.gnt), 1);
        // clear coinciding with fault entry
        fault_cnt_clr = 1'b1;
        pds.fault = 1'b1;
        tick(1);
        chk("t5_clr_entry", 32'(fault_cnt), 1);
        fault_cnt_clr = 1'b0;
        pds.fault = 1'b0;
        tick(1);
        fault_cnt_clr = 1'b1;
        tick(1);
        chk("t5_clr", 32'(fault_cnt), 0);
        fault_cnt_clr = 1'b0;
        // saturation: 300 episodes, no recovery window
        pds.req = 1'b0;
        cfg_recover = 8'd0;
        for (int i = 0; i < 300; i++) begin
            pds.fault = 1'b1;
            tick(1);
            pds.fault = 1'b0;
            tick(1);
            if (i == 99) chk("t5_cnt100", 32'(fault_cnt), 100);
        end
        chk("t5_sat", 32'(fault_cnt), 255);
        chk("t5_sts_idle", 32'(fault_sts), 0);

        // req and fault together in IDLE
        pds.req = 1'b1;
        pds.fault = 1'b1;
        tick(1);
        chk("t5b_nogrant", 32'(pds.gnt), 0);
        chk("t5b_sts", 32'(fault_sts), 1);
        pds.fault = 1'b0;
        tick(1);
        chk("t5b_idle", 32'(fault_sts), 0);
        tick(1);
        chk("t5b_grant", 32'(pds.gnt), 1);

        // reset pulse mid-grant, then re-grant with delay 2
        cfg_gnt_dly = 4'd2;
        rst_n = 1'b0;
        tick(1);
        chk("t6_gnt", 32'(pds.gnt), 0);
        chk("t6_sts", 32'(fault_sts), 0);
        chk("t6_cnt", 32'(fault_cnt), 0);
        rst_n = 1'b1;
        tick(2);
        chk("t6_wait", 32'(pds.gnt), 0);
        tick(1);
        chk("t6_regrant", 32'(pds.gnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
